// File: rtl/ad5791_ctrl.sv
// AD5791 20-bit DAC SPI controller.
// Samples pushed by the flow controller are queued in a small TX FIFO. When
// dac_en rises the DAC control register is written once; after that every
// dac_start strobe shifts one DAC-register frame out and pulses LDAC_n.
module ad5791_ctrl #(
  parameter int                   DATA_NBIT  = 20,
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   SCLK_DIV   = 2,
  parameter int                   SYNC_GAP   = 4,
  parameter int                   LDAC_W     = 2,
  parameter logic [DATA_NBIT-1:0] CTRL_INIT  = 20'h00012
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 dac_start,
  input  logic                 dac_en,
  input  logic                 dac_dv,
  input  logic [DATA_NBIT-1:0] dac_data,
  output logic                 dac_waitrequest,
  output logic                 dac_sclk,
  output logic                 dac_sync_n,
  output logic                 dac_sdin,
  output logic                 dac_ldac_n,
  output logic                 dac_ready,
  output logic                 dac_underrun
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FW  = DATA_NBIT + 4;
  localparam int BW  = $clog2(FW);
  localparam int DVW = $clog2(SCLK_DIV + 1);
  localparam int GW  = $clog2(SYNC_GAP + 1);

  localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0]  BIT_TOP   = BW'(FW - 1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(SCLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(SYNC_GAP - 1);
  localparam logic [GW-1:0]  LDAC_LAST = GW'(LDAC_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CTRL_LOAD, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t state_q, state_d;

  // ---------------- TX FIFO ----------------
  logic [DATA_NBIT-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 waitreq_q, en_q;
  logic                 full_s, empty_s, push_s, pop_s, flush_s;

  assign full_s  = (count_q == FIFO_FULL);
  assign empty_s = (count_q == {CW{1'b0}});
  assign push_s  = dac_dv & ~full_s;
  assign pop_s   = (state_q == S_LOAD) & ~empty_s;
  // dac_en falling discards everything still queued
  assign flush_s = en_q & ~dac_en;

  // FIFO pointer and occupancy next-state; a flush overrides push and pop
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_s) begin
      rd_d    = wr_q;
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) wr_d = wr_q + AW'(1);
      else        wr_d = wr_q;
      if (pop_s)  rd_d = rd_q + AW'(1);
      else        rd_d = rd_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control registers; waitrequest tracks the full condition of the count
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wr_q      <= {AW{1'b0}};
      rd_q      <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      waitreq_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      waitreq_q <= (count_d == FIFO_FULL);
      en_q      <= dac_en;
    end
  end

  // FIFO storage; words written during a flush are discarded
  always_ff @(posedge mclk) begin
    if (push_s && !flush_s) mem_q[wr_q] <= dac_data;
  end

  // ---------------- SPI framing FSM ----------------
  logic [FW-1:0]  shreg_q, shreg_d, frame_s;
  logic [BW-1:0]  bit_q, bit_d;
  logic [DVW-1:0] div_q, div_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           low_q, low_d, ctrl_q, ctrl_d;
  logic           sclk_q, sclk_d, sync_q, sync_d, sdin_q, sdin_d;
  logic           ldac_q, ldac_d, ready_q, ready_d, under_q, under_d;
  logic           div_last_s, en_ready_s;

  assign div_last_s = (div_q == DIV_LAST);
  assign en_ready_s = ready_q & dac_en;
  assign frame_s    = (state_q == S_CTRL_LOAD) ? {1'b0, 3'b010, CTRL_INIT}
                                               : {1'b0, 3'b001, mem_q[rd_q]};

  // State register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dac_en && !ready_q)                     state_d = S_CTRL_LOAD;
        else if (en_ready_s && dac_start && !empty_s) state_d = S_LOAD;
        else                                        state_d = S_IDLE;
      end
      S_CTRL_LOAD, S_LOAD: state_d = S_SHIFT;
      S_SHIFT: begin
        if (low_q && div_last_s && (bit_q == {BW{1'b0}})) state_d = S_GAP;
        else                                              state_d = S_SHIFT;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output pin is registered
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    low_d   = low_q;
    ctrl_d  = ctrl_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    sdin_d  = sdin_q;
    ldac_d  = ldac_q;
    ready_d = en_ready_s;
    under_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_ready_s && dac_start && empty_s) under_d = 1'b1;
        else                                    under_d = 1'b0;
      end
      S_CTRL_LOAD, S_LOAD: begin
        shreg_d = frame_s;
        sdin_d  = frame_s[FW-1];
        ctrl_d  = (state_q == S_CTRL_LOAD);
        bit_d   = BIT_TOP;
        div_d   = {DVW{1'b0}};
        low_d   = 1'b0;
        sclk_d  = 1'b1;
        sync_d  = 1'b0;
      end
      S_SHIFT: begin
        if (!div_last_s) begin
          div_d = div_q + DVW'(1);
        end else begin
          div_d = {DVW{1'b0}};
          if (!low_q) begin
            // falling edge: chip samples the bit held on sdin
            sclk_d = 1'b0;
            low_d  = 1'b1;
          end else begin
            sclk_d = 1'b1;
            low_d  = 1'b0;
            if (bit_q == {BW{1'b0}}) begin
              sync_d = 1'b1;
              gap_d  = {GW{1'b0}};
              ldac_d = ctrl_q;
            end else begin
              bit_d   = bit_q - BW'(1);
              shreg_d = {shreg_q[FW-2:0], 1'b0};
              sdin_d  = shreg_q[FW-2];
            end
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == LDAC_LAST) ldac_d = 1'b1;
        else                    ldac_d = ldac_q;
        if ((gap_q == GAP_LAST) && ctrl_q && dac_en) ready_d = 1'b1;
        else                                         ready_d = en_ready_s;
      end
      default: begin
        sclk_d = 1'b1;
        sync_d = 1'b1;
        ldac_d = 1'b1;
      end
    endcase
  end

  // Datapath and output registers; reset returns the SPI pins to idle at once
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      shreg_q <= {FW{1'b0}};
      bit_q   <= {BW{1'b0}};
      div_q   <= {DVW{1'b0}};
      gap_q   <= {GW{1'b0}};
      low_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      sdin_q  <= 1'b0;
      ldac_q  <= 1'b1;
      ready_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      low_q   <= low_d;
      ctrl_q  <= ctrl_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      sdin_q  <= sdin_d;
      ldac_q  <= ldac_d;
      ready_q <= ready_d;
      under_q <= under_d;
    end
  end

  assign dac_waitrequest = waitreq_q;
  assign dac_sclk        = sclk_q;
  assign dac_sync_n      = sync_q;
  assign dac_sdin        = sdin_q;
  assign dac_ldac_n      = ldac_q;
  assign dac_ready       = ready_q;
  assign dac_underrun    = under_q;

endmodule

// File: tb/tb_ad5791_ctrl.sv
// Self-checking bench for ad5791_ctrl: a SPI decoder rebuilds every frame from
// SCLK falling edges, and a queue-based model predicts FIFO contents, frames,
// LDAC pulses and underruns.
module tb_ad5791_ctrl;

  localparam int DATA_NBIT  = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int SCLK_DIV   = 2;
  localparam int SYNC_GAP   = 4;
  localparam int LDAC_W     = 2;
  localparam logic [23:0] CTRL_FRAME = 24'h200012;

  logic mclk = 1'b0;
  logic rst = 1'b1;
  logic dac_start = 1'b0, dac_en = 1'b0, dac_dv = 1'b0;
  logic [DATA_NBIT-1:0] dac_data = '0;
  logic dac_waitrequest, dac_sclk, dac_sync_n, dac_sdin, dac_ldac_n, dac_ready, dac_underrun;

  int total = 0;
  int bad = 0;

  // monitor state
  logic [23:0] frames[$];
  int          bits[$];
  logic [23:0] m_shift = '0;
  int          m_nbits = 0;
  logic        m_prev_sclk = 1'b1, m_prev_sync = 1'b1;
  int          ldac_cycles = 0, underrun_cycles = 0, sync_low = 0;

  // reference FIFO contents
  logic [DATA_NBIT-1:0] fifo_m[$];

  ad5791_ctrl dut (
    .mclk(mclk), .rst(rst), .dac_start(dac_start), .dac_en(dac_en),
    .dac_dv(dac_dv), .dac_data(dac_data), .dac_waitrequest(dac_waitrequest),
    .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n), .dac_sdin(dac_sdin),
    .dac_ldac_n(dac_ldac_n), .dac_ready(dac_ready), .dac_underrun(dac_underrun)
  );

  always #5 mclk = ~mclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI decoder: the chip samples sdin on SCLK falling edges while SYNC_n is low
  always @(negedge mclk) begin
    if (rst) begin
      m_shift = '0; m_nbits = 0; m_prev_sclk = 1'b1; m_prev_sync = 1'b1;
    end else begin
      if (!dac_sync_n && m_prev_sclk && !dac_sclk) begin
        m_shift = {m_shift[22:0], dac_sdin};
        m_nbits++;
      end
      if (dac_sync_n && !m_prev_sync) begin
        frames.push_back(m_shift);
        bits.push_back(m_nbits);
        m_shift = '0; m_nbits = 0;
      end
      if (!dac_ldac_n) ldac_cycles++;
      if (dac_underrun) underrun_cycles++;
      if (!dac_sync_n) sync_low++;
      m_prev_sclk = dac_sclk;
      m_prev_sync = dac_sync_n;
    end
  end

  task automatic push_word(input logic [DATA_NBIT-1:0] d);
    dac_dv = 1'b1; dac_data = d;
    if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(d);
    @(negedge mclk);
    dac_dv = 1'b0;
  endtask

  // Called right after the strobe (or dac_en) is set up at a falling edge.
  task automatic watch_frame(input logic [23:0] exp, input bit ctrl);
    int n, g, l0;
    bit seen;
    logic [23:0] got;
    int gb;
    l0 = ldac_cycles; seen = 1'b0;
    @(negedge mclk);
    dac_start = 1'b0;
    n = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge mclk);
      if (!dac_sync_n) begin
        seen = 1'b1; n++;
      end else if (seen) begin
        break;
      end
    end
    chk("load_to_rise", n, 1 + 48 * SCLK_DIV);
    chk("ldac_at_rise", dac_ldac_n, ctrl ? 1 : 0);
    if (ctrl) begin
      g = 1;
      for (int i = 0; i < 50 && !dac_ready; i++) begin
        @(negedge mclk);
        if (!dac_ready) g++;
      end
      chk("ready_gap", g, SYNC_GAP);
      repeat (2) @(negedge mclk);
    end else begin
      repeat (SYNC_GAP + 1) @(negedge mclk);
    end
    chk("ldac_width", ldac_cycles - l0, ctrl ? 0 : LDAC_W);
    if (frames.size() == 0) begin
      chk("frame_seen", 0, 1);
    end else begin
      got = frames.pop_front();
      gb  = bits.pop_front();
      chk("frame_bits", gb, 24);
      chk("frame_word", got, exp);
    end
  endtask

  // One dac_start with the outcome predicted by the reference FIFO
  task automatic strobe_and_check();
    int u0, s0;
    logic [23:0] exp;
    if (fifo_m.size() == 0) begin
      u0 = underrun_cycles; s0 = sync_low;
      dac_start = 1'b1;
      @(negedge mclk);
      dac_start = 1'b0;
      repeat (3) @(negedge mclk);
      chk("underrun_pulse", underrun_cycles - u0, 1);
      chk("underrun_sync", sync_low - s0, 0);
    end else begin
      exp = {4'b0001, fifo_m.pop_front()};
      dac_start = 1'b1;
      watch_frame(exp, 1'b0);
    end
  endtask

  initial begin
    int u0;
    logic [23:0] exp;
    // reset state
    repeat (3) @(negedge mclk);
    chk("rst_sclk", dac_sclk, 1);
    chk("rst_sync", dac_sync_n, 1);
    chk("rst_sdin", dac_sdin, 0);
    chk("rst_ldac", dac_ldac_n, 1);
    chk("rst_ready", dac_ready, 0);
    chk("rst_underrun", dac_underrun, 0);
    chk("rst_waitreq", dac_waitrequest, 0);
    rst = 1'b0;
    repeat (2) @(negedge mclk);

    // control register write on enable
    dac_en = 1'b1;
    watch_frame(CTRL_FRAME, 1'b1);
    chk("ready_after_ctrl", dac_ready, 1);

    // single known sample, then FIFO must be empty
    push_word(20'hABCDE);
    strobe_and_check();
    strobe_and_check();

    // fill beyond capacity
    for (int i = 0; i < 5; i++) begin
      push_word(20'h10000 + 20'(i));
      if (i == 2) chk("waitreq_3", dac_waitrequest, 0);
      if (i == 3) chk("waitreq_4", dac_waitrequest, 1);
    end
    strobe_and_check();
    chk("waitreq_after_pop", dac_waitrequest, 0);
    repeat (4) strobe_and_check();

    // dac_start during SHIFT is ignored
    push_word(20'($urandom));
    push_word(20'($urandom));
    u0 = underrun_cycles;
    exp = {4'b0001, fifo_m.pop_front()};
    dac_start = 1'b1;
    fork
      watch_frame(exp, 1'b0);
      begin
        repeat (20) @(negedge mclk);
        dac_start = 1'b1;
        @(negedge mclk);
        dac_start = 1'b0;
      end
    join
    chk("mid_start_no_underrun", underrun_cycles - u0, 0);
    strobe_and_check();
    strobe_and_check();

    // dac_en dropped mid-frame: frame completes, FIFO flushed, ready cleared
    push_word(20'($urandom));
    push_word(20'($urandom));
    exp = {4'b0001, fifo_m.pop_front()};
    fifo_m.delete();
    dac_start = 1'b1;
    fork
      watch_frame(exp, 1'b0);
      begin
        repeat (20) @(negedge mclk);
        dac_en = 1'b0;
      end
    join
    chk("ready_after_en_drop", dac_ready, 0);
    dac_en = 1'b1;
    watch_frame(CTRL_FRAME, 1'b1);
    strobe_and_check();

    // reset mid-frame
    push_word(20'($urandom));
    dac_start = 1'b1;
    @(negedge mclk);
    dac_start = 1'b0;
    repeat (20) @(negedge mclk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sclk", dac_sclk, 1);
    chk("midrst_sync", dac_sync_n, 1);
    chk("midrst_ldac", dac_ldac_n, 1);
    chk("midrst_ready", dac_ready, 0);
    repeat (2) @(negedge mclk);
    fifo_m.delete();
    frames.delete();
    bits.delete();
    rst = 1'b0;
    watch_frame(CTRL_FRAME, 1'b1);
    strobe_and_check();

    // randomized traffic
    for (int it = 0; it < 14; it++) begin
      int n;
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) push_word(20'($urandom));
      @(negedge mclk);
      chk("rand_waitreq", dac_waitrequest, (fifo_m.size() == FIFO_DEPTH) ? 1 : 0);
      strobe_and_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
